// File: rtl/uart_tx_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_tx_sched_pkg : shared types and constants for the UART TX scheduler   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0] TX_ADDR     = 2'b00;
  localparam int         TIMEOUT_DEF = 4096;

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
// +----------------------------------------------------------------------------+
// | uart_tx_sched_if : requester and transmitter signals of the TX scheduler   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   gnt;
  logic              tx_iocs;
  logic              tx_iorw;
  logic [1:0]        tx_ioaddr;
  logic [7:0]        tx_buf;
  logic              tx_tbr;
  logic              busy;
  logic [IW-1:0]     owner;
  logic              timeout_err;

  modport master (
    input  req, req_data, req_last, tx_tbr,
    output gnt, tx_iocs, tx_iorw, tx_ioaddr, tx_buf, busy, owner, timeout_err
  );

  modport slave (
    output req, req_data, req_last, tx_tbr,
    input  gnt, tx_iocs, tx_iorw, tx_ioaddr, tx_buf, busy, owner, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_sched_pick.sv
// +----------------------------------------------------------------------------+
// | uart_tx_sched_pick : combinational winner select; UART_TX_SCHED_RR_EN      |
// | selects round-robin from ptr_i+1, otherwise lowest index wins. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_sched_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifdef UART_TX_SCHED_RR_EN
  input  logic [IW-1:0]   ptr_i,
`endif
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
`ifdef UART_TX_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// +----------------------------------------------------------------------------+
// | uart_tx_sched : shares one UART transmitter among NREQ packet requesters   |
// | with a frame watchdog; UART_TX_SCHED_RR_EN enables round-robin. Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.master bus
);

  localparam int              IW     = $clog2(NREQ);
  localparam int              WW     = $clog2(TIMEOUT);
  localparam logic [WW-1:0]   WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [1:0]      S_IDLE = IDLE;
  localparam logic [1:0]      S_SEND = SEND;
  localparam logic [1:0]      S_HOLD = HOLD;

  logic [1:0]      state_q,  state_d;
  logic [NREQ-1:0] gnt_q,    gnt_d;
  logic            iocs_q,   iocs_d;
  logic            iorw_q,   iorw_d;
  logic [7:0]      buf_q,    buf_d;
  logic [IW-1:0]   owner_q,  owner_d;
  logic            locked_q, locked_d;
  logic            busy_q,   busy_d;
  logic            err_q,    err_d;
  logic [WW-1:0]   wd_q,     wd_d;

  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic            w_load;
  logic [IW-1:0]   w_load_idx;
  logic            w_abort;
  logic            w_wd_exp;

  assign w_wd_exp = (wd_q == WD_MAX);

`ifdef UART_TX_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  uart_tx_sched_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );
`else
  uart_tx_sched_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (bus.req),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    iocs_d     = iocs_q;
    iorw_d     = iorw_q;
    buf_d      = buf_q;
    owner_d    = owner_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    wd_d       = wd_q;
    w_load     = 1'b0;
    w_load_idx = owner_q;
    w_abort    = 1'b0;
`ifdef UART_TX_SCHED_RR_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_load     = 1'b1;
          w_load_idx = w_pick_idx;
`ifdef UART_TX_SCHED_RR_EN
          ptr_d      = w_pick_idx;
`endif
        end
      end
      S_SEND: begin
        // Completion is only meaningful while the strobe is up; it also beats expiry.
        if (iocs_q && bus.tx_tbr) begin
          iocs_d = 1'b0;
          iorw_d = 1'b1;
          wd_d   = '0;
          if (locked_q && bus.req[owner_q]) begin
            w_load = 1'b1;
          end else if (locked_q) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (w_wd_exp) begin
          w_abort = 1'b1;
        end else begin
          wd_d   = wd_q + WW'(1);
          iocs_d = 1'b1;
          iorw_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (bus.req[owner_q]) begin
          w_load = 1'b1;
        end else if (w_wd_exp) begin
          w_abort = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_load) begin
      owner_d            = w_load_idx;
      buf_d              = bus.req_data[{w_load_idx, 3'b000} +: 8];
      locked_d           = ~bus.req_last[w_load_idx];
      gnt_d[w_load_idx]  = 1'b1;
      wd_d               = '0;
      state_d            = S_SEND;
    end

    if (w_abort) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      iocs_d   = 1'b0;
      iorw_d   = 1'b1;
      wd_d     = '0;
      state_d  = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      buf_q    <= 8'h00;
      owner_q  <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
`ifdef UART_TX_SCHED_RR_EN
      ptr_q    <= IW'(NREQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      iocs_q   <= iocs_d;
      iorw_q   <= iorw_d;
      buf_q    <= buf_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
`ifdef UART_TX_SCHED_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.tx_iocs     = iocs_q;
  assign bus.tx_iorw     = iorw_q;
  assign bus.tx_ioaddr   = TX_ADDR;
  assign bus.tx_buf      = buf_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_sched : directed vector bench for uart_tx_sched                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 128;
`ifdef UART_TX_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_fix;
    int          exp_rr;
    logic [7:0]  buf_fix;
    logic [7:0]  buf_rr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_tbr();
    bus.tx_tbr = 1'b1;
    @(negedge clk);
    bus.tx_tbr = 1'b0;
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    chk({name, "_wait"}, 32'(bus.gnt == '0), 32'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.tx_tbr   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int   e;
    int   n;
    int   hi;
    int   bad;
    int   exp_rr_order [5];

    tbl[0] = '{4'b0010, 32'h0000_A500, 1, 1, 8'hA5, 8'hA5};
    tbl[1] = '{4'b1111, 32'h4433_2211, 0, 2, 8'h11, 8'h33};
    tbl[2] = '{4'b0101, 32'h0066_0055, 0, 0, 8'h55, 8'h55};
    tbl[3] = '{4'b1001, 32'h8800_0077, 0, 3, 8'h77, 8'h88};
    tbl[4] = '{4'b1000, 32'h9900_0000, 3, 3, 8'h99, 8'h99};
    tbl[5] = '{4'b0110, 32'h00BB_AA00, 1, 1, 8'hAA, 8'hAA};
    exp_rr_order = '{0, 1, 2, 3, 0};

    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_tbr   = 1'b0;
    step();
    step();
    chk("rst_gnt",   32'(bus.gnt), 0);
    chk("rst_iocs",  32'(bus.tx_iocs), 0);
    chk("rst_iorw",  32'(bus.tx_iorw), 1);
    chk("rst_addr",  32'(bus.tx_ioaddr), 0);
    chk("rst_buf",   32'(bus.tx_buf), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_err",   32'(bus.timeout_err), 0);
    rst = 1'b0;

    // Completion pulse while idle must be ignored.
    pulse_tbr();
    step();
    chk("idle_tbr_busy", 32'(bus.busy), 0);
    chk("idle_tbr_gnt",  32'(bus.gnt), 0);

    // Single-byte frames from idle.
    for (int v = 0; v < 6; v++) begin
      e = RR ? tbl[v].exp_rr : tbl[v].exp_fix;
      bus.req_data = tbl[v].data;
      bus.req_last = '1;
      bus.req      = tbl[v].mask;
      wait_gnt("vec");
      chk("vec_gnt",   32'(bus.gnt), 32'(1 << e));
      chk("vec_buf",   32'(bus.tx_buf), 32'(RR ? tbl[v].buf_rr : tbl[v].buf_fix));
      chk("vec_owner", 32'(bus.owner), 32'(e));
      chk("vec_busy",  32'(bus.busy), 1);
      chk("vec_iocs0", 32'(bus.tx_iocs), 0);
      bus.req = '0;
      step();
      chk("vec_iocs1", 32'(bus.tx_iocs), 1);
      chk("vec_iorw0", 32'(bus.tx_iorw), 0);
      chk("vec_gnt_1c", 32'(bus.gnt), 0);
      chk("vec_addr",  32'(bus.tx_ioaddr), 0);
      repeat (3) step();
      chk("vec_hold_strobe", 32'({bus.tx_iocs, bus.tx_iorw}), 32'b10);
      pulse_tbr();
      chk("vec_done_strobe", 32'({bus.tx_iocs, bus.tx_iorw}), 32'b01);
      chk("vec_done_busy",   32'(bus.busy), 0);
      chk("vec_done_owner",  32'(bus.owner), 32'(e));
    end

    // Packet lock: requester 0 sends 11,22,33 while requester 2 waits.
    do_reset();
    bus.req_data = 32'h0044_0011;
    bus.req_last = 4'b0100;
    bus.req      = 4'b0101;
    wait_gnt("pk1");
    chk("pk1_gnt", 32'(bus.gnt), 32'b0001);
    chk("pk1_buf", 32'(bus.tx_buf), 32'h11);
    bus.req_data[7:0] = 8'h22;
    step();
    chk("pk1_iocs", 32'(bus.tx_iocs), 1);
    pulse_tbr();
    chk("pk2_gnt",  32'(bus.gnt), 32'b0001);
    chk("pk2_buf",  32'(bus.tx_buf), 32'h22);
    chk("pk2_gap",  32'(bus.tx_iocs), 0);
    bus.req_data[7:0] = 8'h33;
    bus.req_last[0]   = 1'b1;
    step();
    chk("pk2_iocs", 32'(bus.tx_iocs), 1);
    pulse_tbr();
    chk("pk3_gnt", 32'(bus.gnt), 32'b0001);
    chk("pk3_buf", 32'(bus.tx_buf), 32'h33);
    bus.req[0] = 1'b0;
    step();
    pulse_tbr();
    chk("pk3_end_gnt",  32'(bus.gnt), 0);
    chk("pk3_end_busy", 32'(bus.busy), 0);
    step();
    chk("pk4_gnt",   32'(bus.gnt), 32'b0100);
    chk("pk4_buf",   32'(bus.tx_buf), 32'h44);
    chk("pk4_owner", 32'(bus.owner), 2);
    bus.req = '0;
    step();
    pulse_tbr();
    chk("pk4_busy", 32'(bus.busy), 0);

    // Arbitration order with every requester asking.
    do_reset();
    bus.req_data = 32'h5352_5150;
    bus.req_last = '1;
    bus.req      = '1;
    for (int k = 0; k < 5; k++) begin
      e = RR ? exp_rr_order[k] : 0;
      wait_gnt("arb");
      chk("arb_gnt", 32'(bus.gnt), 32'(1 << e));
      chk("arb_buf", 32'(bus.tx_buf), 32'(8'h50 + e));
      step();
      if (k == 4) bus.req = '0;
      pulse_tbr();
    end

    // HOLD: owner 3 pauses mid-packet; requester 1 must not be served.
    do_reset();
    bus.req_data = 32'h7700_9900;
    bus.req_last = 4'b0010;
    bus.req      = 4'b1000;
    wait_gnt("hold");
    chk("hold_gnt", 32'(bus.gnt), 32'b1000);
    chk("hold_buf", 32'(bus.tx_buf), 32'h77);
    bus.req = 4'b0010;
    step();
    chk("hold_iocs", 32'(bus.tx_iocs), 1);
    pulse_tbr();
    chk("hold_enter_iocs", 32'(bus.tx_iocs), 0);
    chk("hold_enter_busy", 32'(bus.busy), 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus.tx_tbr = (i == 50);
      step();
      if (bus.gnt != '0 || bus.timeout_err || !bus.busy || bus.tx_iocs) bad++;
    end
    bus.tx_tbr = 1'b0;
    chk("hold_quiet", 32'(bad), 0);
    bus.req_data[31:24] = 8'h88;
    bus.req_last[3]     = 1'b1;
    bus.req             = 4'b1010;
    step();
    chk("hold_resume_gnt", 32'(bus.gnt), 32'b1000);
    chk("hold_resume_buf", 32'(bus.tx_buf), 32'h88);
    bus.req = 4'b0010;
    step();
    chk("hold_resume_iocs", 32'(bus.tx_iocs), 1);
    pulse_tbr();
    chk("hold_done_busy", 32'(bus.busy), 0);
    wait_gnt("hold_next");
    chk("hold_next_gnt", 32'(bus.gnt), 32'b0010);
    chk("hold_next_buf", 32'(bus.tx_buf), 32'h99);
    bus.req = '0;
    step();
    pulse_tbr();

    // Watchdog expiry with no completion pulse.
    do_reset();
    bus.req_data = 32'h0000_C1C0;
    bus.req_last = '1;
    bus.req      = 4'b0011;
    wait_gnt("wd");
    chk("wd_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0010;
    n  = 0;
    hi = 0;
    do begin
      step();
      n++;
      if (bus.tx_iocs) hi++;
    end while (!bus.timeout_err && n < 2 * TIMEOUT);
    chk("wd_cycles",    32'(n), 32'(TIMEOUT));
    chk("wd_strobe_hi", 32'(hi), 32'(TIMEOUT - 1));
    chk("wd_strobe",    32'({bus.tx_iocs, bus.tx_iorw}), 32'b01);
    chk("wd_busy",      32'(bus.busy), 0);
    step();
    chk("wd_err_pulse", 32'(bus.timeout_err), 0);
    chk("wd_next_gnt",  32'(bus.gnt), 32'b0010);
    chk("wd_next_buf",  32'(bus.tx_buf), 32'hC1);
    bus.req = '0;
    step();
    pulse_tbr();
    chk("wd_next_done", 32'(bus.busy), 0);

    // Completion on the very cycle the watchdog would expire.
    do_reset();
    bus.req_data = 32'h0000_00D0;
    bus.req_last = '1;
    bus.req      = 4'b0001;
    wait_gnt("tie");
    bus.req = '0;
    repeat (TIMEOUT - 1) step();
    pulse_tbr();
    chk("tie_err",  32'(bus.timeout_err), 0);
    chk("tie_busy", 32'(bus.busy), 0);
    step();
    chk("tie_err2", 32'(bus.timeout_err), 0);

    // Asynchronous reset mid-frame.
    do_reset();
    bus.req_data = 32'h00E2_0000;
    bus.req_last = '1;
    bus.req      = 4'b0100;
    wait_gnt("ar");
    chk("ar_gnt", 32'(bus.gnt), 32'b0100);
    rst = 1'b1;
    #1;
    chk("ar_gnt_clr", 32'(bus.gnt), 0);
    chk("ar_busy",    32'(bus.busy), 0);
    chk("ar_owner",   32'(bus.owner), 0);
    chk("ar_buf",     32'(bus.tx_buf), 0);
    step();
    rst = 1'b0;
    wait_gnt("ar2");
    chk("ar2_gnt", 32'(bus.gnt), 32'b0100);
    step();
    chk("ar2_iocs", 32'(bus.tx_iocs), 1);
    rst = 1'b1;
    #1;
    chk("ar2_strobe", 32'({bus.tx_iocs, bus.tx_iorw}), 32'b01);
    step();
    rst = 1'b0;
    wait_gnt("ar3");
    chk("ar3_gnt", 32'(bus.gnt), 32'b0100);
    chk("ar3_buf", 32'(bus.tx_buf), 32'hE2);
    bus.req = '0;
    step();
    pulse_tbr();
    chk("ar3_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
